row_secded_dec: RTL and testbench

Parametrised, pipelined SECDED decoder for Gray-coded row addresses carried in the emulated FE data stream. It extends plain single-error-correcting Hamming row decoding in four ways: a configurable address width, an extra overall-parity bit for double-error detection, a valid/ready pipeline with backpressure, and saturating error counters. It sits between the hit-word deserialiser and the hit formatter.

---
 rtl/row_secded_dec.sv | 132 +++++++++++++
 tb/tb_row_secded_dec.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_secded_dec.sv
// row_secded_dec: two-stage SECDED decoder for Gray-coded row addresses
// with valid/ready backpressure and saturating error counters.
module row_secded_dec #(
    parameter int ADDR_W = 8,
    parameter int GRAY   = 1,
    parameter int CNT_W  = 16,
    localparam int P     = (ADDR_W <= 1)  ? 2 :
                           (ADDR_W <= 4)  ? 3 :
                           (ADDR_W <= 11) ? 4 :
                           (ADDR_W <= 26) ? 5 :
                           (ADDR_W <= 57) ? 6 : 7,
    localparam int CW_W  = ADDR_W + P + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CW_W-1:0]   in_cw,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_sec,
    output logic              out_ded,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_sec,
    output logic [CNT_W-1:0]  cnt_ded
);

    localparam int NPOS = CW_W - 1;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] dat;
        logic [P-1:0]      syn;
        logic              ovr;
    } s1_t;

    // Codeword index of data bit k: k-th non-power-of-two Hamming position.
    function automatic int data_idx(input int k);
        int n;
        int r;
        n = 0;
        r = 0;
        for (int pos = 1; pos < CW_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (n == k) r = pos - 1;
                n++;
            end
        end
        return r;
    endfunction

    s1_t               s1_q;
    s1_t               s1_d;
    logic [ADDR_W-1:0] in_dat;
    logic [ADDR_W-1:0] raw;
    logic [ADDR_W-1:0] bin;
    logic [ADDR_W-1:0] fix;
    logic              in_rng;
    logic              sec;
    logic              ded;
    logic              acc;
    logic              adv;
    logic              xfer;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign xfer     = out_valid && out_ready;

    for (genvar k = 0; k < ADDR_W; k++) begin : g_data
        localparam int DI = data_idx(k);
        assign in_dat[k] = in_cw[DI];
        assign fix[k]    = sec && (s1_q.syn == P'(DI + 1));
    end

    always_comb begin
        s1_d.valid = in_valid;
        s1_d.dat   = in_dat;
        s1_d.syn   = '0;
        for (int i = 0; i < NPOS; i++) begin
            if (in_cw[i]) s1_d.syn = s1_d.syn ^ P'(i + 1);
        end
        s1_d.ovr = ^in_cw;
    end

    // Syndromes beyond the last position are double errors in disguise.
    always_comb begin
        in_rng = (s1_q.syn <= P'(NPOS));
        sec    = s1_q.ovr && in_rng;
        ded    = s1_q.ovr ? !in_rng : (s1_q.syn != '0);
        raw    = s1_q.dat ^ fix;
    end

    always_comb begin
        bin = raw;
        acc = 1'b0;
        for (int k = ADDR_W - 1; k >= 0; k--) begin
            acc = acc ^ raw[k];
            if (GRAY != 0) bin[k] = acc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_sec   <= 1'b0;
            out_ded   <= 1'b0;
        end else if (adv) begin
            s1_q      <= s1_d;
            out_valid <= s1_q.valid;
            out_addr  <= bin;
            out_sec   <= s1_q.valid && sec;
            out_ded   <= s1_q.valid && ded;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_sec <= '0;
            cnt_ded <= '0;
        end else if (cnt_clr) begin
            cnt_sec <= '0;
            cnt_ded <= '0;
        end else if (xfer) begin
            if (out_sec && (cnt_sec != '1)) cnt_sec <= cnt_sec + CNT_W'(1);
            if (out_ded && (cnt_ded != '1)) cnt_ded <= cnt_ded + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_row_secded_dec.sv
// tb_row_secded_dec: random and directed stimulus against a codeword-level
// model of the SECDED row decoder.
module tb_row_secded_dec;

    typedef struct {
        logic [7:0] addr;
        logic       sec;
        logic       ded;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [12:0] in_cw = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_addr;
    logic        out_sec;
    logic        out_ded;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        cnt_clr = 1'b0;
    logic [15:0] cnt_sec;
    logic [15:0] cnt_ded;

    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        q[$];
    exp_t        cur;
    exp_t        ce;
    logic [15:0] m_sec = '0;
    logic [15:0] m_ded = '0;
    logic        prev_stall = 1'b0;
    logic [7:0]  p_addr;
    logic        p_sec;
    logic        p_ded;

    row_secded_dec #(.ADDR_W(8), .GRAY(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_cw(in_cw), .in_valid(in_valid), .in_ready(in_ready),
        .out_addr(out_addr), .out_sec(out_sec), .out_ded(out_ded),
        .out_valid(out_valid), .out_ready(out_ready),
        .cnt_clr(cnt_clr), .cnt_sec(cnt_sec), .cnt_ded(cnt_ded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [12:0] enc(input logic [7:0] a);
        logic [7:0]  g;
        logic [12:0] cw;
        logic        par;
        int          k;
        g  = a ^ (a >> 1);
        cw = '0;
        k  = 0;
        for (int pos = 1; pos <= 12; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos-1] = g[k];
                k++;
            end
        end
        for (int j = 0; j < 4; j++) begin
            par = 1'b0;
            for (int pos = 1; pos <= 12; pos++) begin
                if (((pos >> j) & 1) == 1 && (pos & (pos - 1)) != 0)
                    par = par ^ cw[pos-1];
            end
            cw[(1 << j) - 1] = par;
        end
        cw[12] = ^cw[11:0];
        return cw;
    endfunction

    function automatic logic [7:0] extract(input logic [12:0] cw);
        logic [7:0] g;
        int         k;
        g = '0;
        k = 0;
        for (int pos = 1; pos <= 12; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                g[k] = cw[pos-1];
                k++;
            end
        end
        return g;
    endfunction

    function automatic logic [7:0] g2b(input logic [7:0] g);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) b = b ^ (g >> i);
        return b;
    endfunction

    task automatic gen(input int nflip, output logic [12:0] cw, output exp_t e);
        logic [7:0] a;
        int         i1;
        int         i2;
        a  = 8'($urandom_range(0, 255));
        cw = enc(a);
        i1 = int'($urandom_range(0, 12));
        i2 = (i1 + int'($urandom_range(1, 12))) % 13;
        if (nflip >= 1) cw[i1] = ~cw[i1];
        if (nflip >= 2) cw[i2] = ~cw[i2];
        e.addr = (nflip >= 2) ? g2b(extract(cw)) : a;
        e.sec  = (nflip == 1);
        e.ded  = (nflip == 2);
    endtask

    // Per-cycle compare against the expectation queue and counter model.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_sec      = '0;
            m_ded      = '0;
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            chk("cnt_sec", 32'(cnt_sec), 32'(m_sec));
            chk("cnt_ded", 32'(cnt_ded), 32'(m_ded));
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_addr", 32'(out_addr), 32'(p_addr));
                chk("stall_flags", 32'({out_sec, out_ded}), 32'({p_sec, p_ded}));
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("no_word_expected", 32'(out_valid), 0);
                end else begin
                    ce = q[0];
                    chk("out_addr", 32'(out_addr), 32'(ce.addr));
                    chk("out_sec", 32'(out_sec), 32'(ce.sec));
                    chk("out_ded", 32'(out_ded), 32'(ce.ded));
                    if (out_ready) begin
                        void'(q.pop_front());
                        if (!cnt_clr) begin
                            if (ce.sec && m_sec != 16'hFFFF) m_sec = m_sec + 16'd1;
                            if (ce.ded && m_ded != 16'hFFFF) m_ded = m_ded + 16'd1;
                        end
                    end
                end
            end
            if (cnt_clr) begin
                m_sec = '0;
                m_ded = '0;
            end
            prev_stall = out_valid && !out_ready;
            p_addr     = out_addr;
            p_sec      = out_sec;
            p_ded      = out_ded;
            if (in_valid && in_ready) q.push_back(cur);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic direct(input string nm, input logic [12:0] cw,
                          input logic [7:0] ea, input logic es, input logic ed);
        out_ready = 1'b1;
        in_cw     = cw;
        cur       = '{ea, es, ed};
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_lat1"}, 32'(out_valid), 0);
        @(negedge clk);
        chk({nm, "_lat2"}, 32'(out_valid), 1);
        chk({nm, "_addr"}, 32'(out_addr), 32'(ea));
        chk({nm, "_sec"}, 32'(out_sec), 32'(es));
        chk({nm, "_ded"}, 32'(out_ded), 32'(ed));
        tick();
    endtask

    // mode 0: clean words, ready 1,0,0; mode 1: random; mode 2: single errors
    task automatic stream(input int nw, input int mode);
        int          idx;
        int          cyc;
        int          budget;
        int          nf;
        logic [12:0] cw;
        exp_t        e;
        idx    = 0;
        cyc    = 0;
        budget = (mode == 2) ? nw + 50 : nw * 4 + 50;
        nf     = (mode == 0) ? 0 : (mode == 2) ? 1 : int'($urandom_range(0, 2));
        gen(nf, cw, e);
        while ((idx < nw || q.size() != 0) && cyc < budget) begin
            case (mode)
                0: out_ready = (cyc % 3 == 0);
                1: begin
                    out_ready = ($urandom_range(0, 9) < 6);
                    cnt_clr   = ($urandom_range(0, 49) == 0);
                end
                default: out_ready = 1'b1;
            endcase
            in_valid = (idx < nw) && (mode != 1 || $urandom_range(0, 9) < 7);
            in_cw    = cw;
            cur      = e;
            @(negedge clk);
            if (in_valid && in_ready) begin
                idx++;
                nf = (mode == 0) ? 0 : (mode == 2) ? 1 : int'($urandom_range(0, 2));
                gen(nf, cw, e);
            end
            tick();
            cyc++;
        end
        chk("stream_sent", idx, nw);
        chk("stream_drain", q.size(), 0);
        in_valid  = 1'b0;
        cnt_clr   = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cur = '{8'h00, 1'b0, 1'b0};
        chk("pin_enc_00", 32'(enc(8'h00)), 32'h0000);
        chk("pin_enc_01", 32'(enc(8'h01)), 32'h1007);
        chk("pin_enc_ff", 32'(enc(8'hFF)), 32'h1888);
        chk("pin_ded_addr", 32'(g2b(extract(13'h188B))), 32'hFF);

        @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_addr", 32'(out_addr), 0);
        chk("rst_flags", 32'({out_sec, out_ded}), 0);
        chk("rst_cnt", 32'({cnt_sec, cnt_ded}), 0);
        chk("rst_ready", 32'(in_ready), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();

        direct("zero", 13'h0000, 8'h00, 1'b0, 1'b0);
        chk("zero_cnt", 32'({cnt_sec, cnt_ded}), 0);
        direct("clean_ff", 13'h1888, 8'hFF, 1'b0, 1'b0);
        direct("sec_idx11", 13'h1088, 8'hFF, 1'b1, 1'b0);
        chk("sec_cnt1", 32'(cnt_sec), 1);
        direct("sec_ovr", 13'h0888, 8'hFF, 1'b1, 1'b0);
        chk("sec_cnt2", 32'(cnt_sec), 2);
        direct("ded_s3", 13'h188B, 8'hFF, 1'b0, 1'b1);
        chk("ded_cnt1", 32'(cnt_ded), 1);
        chk("ded_cnt_sec", 32'(cnt_sec), 2);

        stream(8, 0);
        stream(600, 1);
        stream(65540, 2);
        chk("sat_reached", 32'(cnt_sec), 32'hFFFF);
        direct("sat_more", enc(8'h3C) ^ 13'h0100, 8'h3C, 1'b1, 1'b0);
        chk("sat_hold", 32'(cnt_sec), 32'hFFFF);

        in_cw    = enc(8'h5A) ^ 13'h0010;
        cur      = '{8'h5A, 1'b1, 1'b0};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        cnt_clr = 1'b1;
        @(negedge clk);
        chk("clr_xfer_valid", 32'(out_valid), 1);
        tick();
        cnt_clr = 1'b0;
        chk("clr_prio", 32'(cnt_sec), 0);

        direct("pre_rst", enc(8'h11) ^ 13'h0001, 8'h11, 1'b1, 1'b0);
        chk("pre_rst_cnt", 32'(cnt_sec), 1);
        out_ready = 1'b0;
        in_cw     = enc(8'h21);
        cur       = '{8'h21, 1'b0, 1'b0};
        in_valid  = 1'b1;
        tick();
        in_cw = enc(8'h42);
        cur   = '{8'h42, 1'b0, 1'b0};
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("inflight_valid", 32'(out_valid), 1);
        chk("inflight_ready", 32'(in_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid), 0);
        chk("async_cnt_sec", 32'(cnt_sec), 0);
        chk("async_cnt_ded", 32'(cnt_ded), 0);
        chk("async_ready", 32'(in_ready), 1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        direct("post_rst", 13'h1888, 8'hFF, 1'b0, 1'b0);
        tick();
        chk("final_drain", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
